rx_word_timer: RTL and testbench
================================

# rx_word_timer

Parametrised bipolar-line word receiver timer: the successor to the fixed-rate pulse-counting timer in the line-receiver front end. It generates the sampling enable `ce` at `NP` ticks per bit for a run-time selectable bit rate and synchronises the `rxp`/`rxn` line pulses. It delimits words by an inter-word gap, counts pulses per word and reports a classified error code with a single-cycle word-end strobe. It sits between the line comparators and the shift-register/decoder stage.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency.
- `NP`, 100, `ce` ticks per bit period.
- `WORD_BITS`, 32, expected pulses per word (1..255).
- `GAP_BITS`, 3, gap length in bit periods that terminates a word.
- `TOL`, 10, allowed deviation in `ce` ticks of the pulse spacing from `NP`; used only when spacing check is compiled in.

- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rate_sel` in 2: bit rate select. 00 = 100 kbit/s, 01 = 50 kbit/s, 10 and 11 = 12.5 kbit/s.
- `rxp` in 1: positive line pulse, asynchronous.
- `rxn` in 1: negative line pulse, asynchronous.
- `ce` out 1: one-`clk` enable, period `CLK_HZ/(rate*NP)` clocks.
- `word_end` out 1: one-`clk` strobe marking a completed word.
- `n_pulses` out 8: pulse count of the last completed word.
- `err` out 1: OR of `err_code` for the last word.
- `err_code` out 3: bit0 = count ≠ `WORD_BITS`, bit1 = both lines high, bit2 = spacing violation.
- `busy` out 1: high while a word is in progress.

## Operation
- **Divider.** The divisor is `CLK_HZ/(rate*NP)` per `rate_sel`, with the width taken from `$clog2` of the largest divisor. `rate_sel` is latched only in IDLE; changes during a word are ignored until the next IDLE. On a latch change the divider restarts from 1.
- **Input path.** Each of `rxp`/`rxn` passes through a 2-flop synchroniser on `clk` and is then sampled on `ce`.
- **Edge detection.** A pulse edge is a rising edge of the `ce`-sampled value on either line. Edges on both lines in the same tick count as one pulse and set bit1. Both sampled lines high on any tick inside a word also sets bit1.
- **FSM.**
  - IDLE: the first edge loads count = 1, clears the gap counter and error bits, and moves to WORD.
  - WORD: each edge increments the count (saturating at 255) and clears the gap counter. Otherwise the gap counter increments each tick. When it reaches `GAP_BITS*NP-1`, the FSM moves to END.
  - END: lasts one tick. It loads `n_pulses`, sets `err_code[0]` if count ≠ `WORD_BITS`, latches `err_code` and `err`, pulses `word_end`, and returns to IDLE.
- **Output hold.** `n_pulses`, `err` and `err_code` hold until the next END.
- **`busy`.** High in WORD and END.
- **Reset.** All outputs, counters and the FSM return to 0/IDLE. A word in progress is discarded with no `word_end`.

## Timing
- Input to sampled value: 2 `clk` of synchroniser latency plus up to one `ce` period.
- An edge detected on tick k with no further edges gives `word_end` in the `clk` cycle of tick k + `GAP_BITS*NP`.
- `word_end` is high for exactly one `clk`, coincident with `ce`.
- `ce` is never asserted while `rst_n` is low. The first `ce` comes a full divisor period after reset release.

## Configuration
- `RX_WORD_TIMER_SPACING_CHECK_EN` defined:
  - An interval counter measures ticks between successive edges within a word.
  - Bit2 is set if an interval is outside `NP±TOL`.
  - The first edge of a word is exempt.
- Not defined: no interval counter, and bit2 is constant 0.

## Structure
- Package `rx_word_timer_pkg` holds:
  - `rate_sel` encoding constants and the rate table;
  - `err_code` bit indices;
  - the FSM state typedef (IDLE, WORD, END).
- Sub-module `rx_ce_gen` contains the divider plus rate latch and produces `ce`.

## Test plan
All scenarios use `CLK_HZ`=50M and `NP`=100, so `ce` has a period of 5/10/40 clk.
- 32 alternating `rxp`/`rxn` pulses at 100k, `rate_sel`=00: expect one `word_end` 300 ticks after the last edge, `n_pulses`=32, `err_code`=000.
- 31 pulses: expect `n_pulses`=31, `err_code`=001, `err`=1.
- `rxp` and `rxn` both high during pulse 5 of 32: expect `n_pulses`=32, `err_code`=010.
- `rate_sel`=10 with 32 pulses at 12.5k: expect a `ce` period of 40 clk, `n_pulses`=32, `err`=0.
- Pulse 10 delayed by 20 ticks: with the macro, expect `err_code`=100; without it, `err_code`=000; `n_pulses`=32 in both cases.
- `rst_n` pulsed low after 16 pulses: expect all outputs 0 and no `word_end`; a following full word reports `n_pulses`=32 with `err`=0.

Source files
------------

// File: rtl/rx_word_timer_pkg.sv
// Shared constants, rate table and FSM states for rx_word_timer.
// Optional spacing check: RX_WORD_TIMER_SPACING_CHECK_EN.
package rx_word_timer_pkg;

    localparam logic [1:0] RATE_100K = 2'b00;
    localparam logic [1:0] RATE_50K  = 2'b01;
    localparam logic [1:0] RATE_12K5 = 2'b10;

    localparam int HZ_100K = 100_000;
    localparam int HZ_50K  = 50_000;
    localparam int HZ_12K5 = 12_500;

    localparam int ERR_COUNT   = 0;
    localparam int ERR_BOTH    = 1;
    localparam int ERR_SPACING = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WORD = 2'd1,
        END  = 2'd2
    } state_t;

    // Codes 10 and 11 both select the slowest rate.
    function automatic logic [1:0] rate_norm(input logic [1:0] sel);
        return sel[1] ? RATE_12K5 : sel;
    endfunction

    function automatic int rate_hz(input logic [1:0] sel);
        case (rate_norm(sel))
            RATE_100K: return HZ_100K;
            RATE_50K:  return HZ_50K;
            default:   return HZ_12K5;
        endcase
    endfunction

endpackage

// File: rtl/rx_word_timer_if.sv
// Line-side and result bundle of rx_word_timer.
// master = environment, slave = receiver timer.
interface rx_word_timer_if;
    logic [1:0] rate_sel;
    logic       rxp;
    logic       rxn;
    logic       ce;
    logic       word_end;
    logic [7:0] n_pulses;
    logic       err;
    logic [2:0] err_code;
    logic       busy;

    modport master (
        output rate_sel, rxp, rxn,
        input  ce, word_end, n_pulses, err, err_code, busy
    );

    modport slave (
        input  rate_sel, rxp, rxn,
        output ce, word_end, n_pulses, err, err_code, busy
    );
endinterface

// File: rtl/rx_ce_gen.sv
// Sampling-enable divider with a rate latch that only follows
// rate_sel while the receiver is idle.
module rx_ce_gen
    import rx_word_timer_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int NP     = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] rate_sel_i,
    input  logic       idle_i,
    output logic       ce_o
);

    localparam int DIV_FAST = CLK_HZ / (rate_hz(RATE_100K) * NP);
    localparam int DIV_MID  = CLK_HZ / (rate_hz(RATE_50K) * NP);
    localparam int DIV_SLOW = CLK_HZ / (rate_hz(RATE_12K5) * NP);
    localparam int CW = (DIV_SLOW > 1) ? $clog2(DIV_SLOW) : 1;

    logic [1:0]    rate_q, rate_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ce_q, ce_d;
    logic [CW-1:0] last;

    // Terminal count for the latched rate.
    always_comb begin
        last = CW'(DIV_SLOW - 1);
        case (rate_q)
            RATE_100K: last = CW'(DIV_FAST - 1);
            RATE_50K:  last = CW'(DIV_MID - 1);
            default:   last = CW'(DIV_SLOW - 1);
        endcase
    end

    // Latch a new rate in idle and restart; otherwise count and tick.
    always_comb begin
        rate_d = rate_q;
        cnt_d  = cnt_q;
        ce_d   = 1'b0;
        if (idle_i && (rate_norm(rate_sel_i) != rate_q)) begin
            rate_d = rate_norm(rate_sel_i);
            cnt_d  = '0;
        end else if (cnt_q == last) begin
            cnt_d = '0;
            ce_d  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Divider state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_q <= RATE_100K;
            cnt_q  <= '0;
            ce_q   <= 1'b0;
        end else begin
            rate_q <= rate_d;
            cnt_q  <= cnt_d;
            ce_q   <= ce_d;
        end
    end

    assign ce_o = ce_q;

endmodule

// File: rtl/rx_word_timer.sv
// Bipolar-line word receiver timer: gap-delimited pulse counting.
// Spacing check compiled in with RX_WORD_TIMER_SPACING_CHECK_EN.
module rx_word_timer
    import rx_word_timer_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int NP        = 100,
    parameter int WORD_BITS = 32,
    parameter int GAP_BITS  = 3,
    parameter int TOL       = 10
) (
    input logic           clk,
    input logic           rst_n,
    rx_word_timer_if.slave bus
);

    localparam int GAP_LAST = GAP_BITS * NP - 1;
    localparam int GW = (GAP_LAST > 1) ? $clog2(GAP_LAST + 1) : 1;

    state_t        state_q, state_d;
    logic          ce;
    logic [1:0]    sync1_q, sync2_q, smp_q;
    logic [1:0]    rise;
    logic          edge_hit, both_hi, sp_bad, wend;
    logic [7:0]    cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          both_q, both_d;
    logic          sperr_q, sperr_d;
    logic [7:0]    npul_q, npul_d;
    logic [2:0]    code_q, code_d;
    logic          err_q, err_d;

    rx_ce_gen #(
        .CLK_HZ(CLK_HZ),
        .NP    (NP)
    ) u_ce (
        .clk       (clk),
        .rst_n     (rst_n),
        .rate_sel_i(bus.rate_sel),
        .idle_i    (state_q == IDLE),
        .ce_o      (ce)
    );

    // Two-flop synchronisers, then sample on each tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            smp_q   <= '0;
        end else begin
            sync1_q <= {bus.rxn, bus.rxp};
            sync2_q <= sync1_q;
            if (ce) smp_q <= sync2_q;
        end
    end

    assign rise     = ce ? (sync2_q & ~smp_q) : 2'b00;
    assign edge_hit = |rise;
    assign both_hi  = ce & (&sync2_q);

`ifdef RX_WORD_TIMER_SPACING_CHECK_EN
    localparam int IW = $clog2(NP + TOL + 1);
    localparam logic [IW-1:0] IV_LO  = IW'(NP - TOL - 1);
    localparam logic [IW-1:0] IV_HI  = IW'(NP + TOL - 1);
    localparam logic [IW-1:0] IV_MAX = IW'(NP + TOL);

    logic [IW-1:0] iv_q, iv_d;

    // Ticks since the previous edge, saturating just past the window.
    always_comb begin
        iv_d = iv_q;
        if (ce && edge_hit) begin
            iv_d = '0;
        end else if (ce && (state_q == WORD) && (iv_q != IV_MAX)) begin
            iv_d = iv_q + 1'b1;
        end
    end

    // Interval register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) iv_q <= '0;
        else        iv_q <= iv_d;
    end

    assign sp_bad = (iv_q < IV_LO) || (iv_q > IV_HI);
`else
    assign sp_bad = 1'b0;
`endif

    // Word FSM: advances only on ticks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        both_d  = both_q;
        sperr_d = sperr_q;
        npul_d  = npul_q;
        code_d  = code_q;
        err_d   = err_q;
        wend    = 1'b0;
        if (ce) begin
            unique case (state_q)
                IDLE: begin
                    if (edge_hit) begin
                        cnt_d   = 8'd1;
                        gap_d   = '0;
                        both_d  = both_hi;
                        sperr_d = 1'b0;
                        state_d = WORD;
                    end
                end
                WORD: begin
                    if (both_hi) both_d = 1'b1;
                    if (edge_hit) begin
                        if (cnt_q != 8'hFF) cnt_d = cnt_q + 1'b1;
                        gap_d = '0;
                        if (sp_bad) sperr_d = 1'b1;
                    end else begin
                        gap_d = gap_q + 1'b1;
                        if (gap_q == GW'(GAP_LAST - 1)) state_d = END;
                    end
                end
                END: begin
                    npul_d = cnt_q;
                    code_d[ERR_COUNT]   = (cnt_q != 8'(WORD_BITS));
                    code_d[ERR_BOTH]    = both_q;
                    code_d[ERR_SPACING] = sperr_q;
                    err_d   = |code_d;
                    wend    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            both_q  <= 1'b0;
            sperr_q <= 1'b0;
            npul_q  <= '0;
            code_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            both_q  <= both_d;
            sperr_q <= sperr_d;
            npul_q  <= npul_d;
            code_q  <= code_d;
            err_q   <= err_d;
        end
    end

    assign bus.ce       = ce;
    assign bus.word_end = wend;
    assign bus.n_pulses = npul_q;
    assign bus.err      = err_q;
    assign bus.err_code = code_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_rx_word_timer.sv
// Directed/randomised bench for rx_word_timer.
// Clock scaled with NP so ce periods stay 5/10/40 clk.
module tb_rx_word_timer;

    localparam int CLK_HZ    = 10_000_000;
    localparam int NP        = 20;
    localparam int WORD_BITS = 32;
    localparam int GAP_BITS  = 3;
    localparam int TOL       = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rx_word_timer_if w();

    rx_word_timer #(
        .CLK_HZ   (CLK_HZ),
        .NP       (NP),
        .WORD_BITS(WORD_BITS),
        .GAP_BITS (GAP_BITS),
        .TOL      (TOL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (w)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit dead = 1'b0;
    int cur_div = 5;
    int n;
    int st[64];
    int wd[64];
    int ln[64];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the negedge of the next ce cycle; returns clocks taken.
    task automatic wait_tick(output int clks);
        clks = 0;
        if (dead) return;
        do begin
            @(negedge clk);
            clks++;
        end while (w.ce !== 1'b1 && clks < 200);
        if (w.ce !== 1'b1) begin
            dead = 1'b1;
            checks++;
            errors++;
            $error("FAIL ce_timeout: got no ce expected one within 200 clk");
        end
    endtask

    // Pulse schedule: start tick, width, line (0=p,1=n,2=both).
    task automatic build(input int cnt, input int both_idx,
                         input int dly_idx, input int dly,
                         input bit rnd);
        int t;
        t = 2;
        n = cnt;
        for (int i = 0; i < cnt; i++) begin
            if (i > 0) t += rnd ? (NP - TOL + $urandom_range(2 * TOL)) : NP;
            if (i == dly_idx) t += dly;
            st[i] = t;
            wd[i] = 1 + $urandom_range(NP / 2 - 1);
            if (i == both_idx) ln[i] = 2;
            else ln[i] = rnd ? $urandom_range(1) : (i % 2);
        end
    endtask

    task automatic run_word(input string tag, input bit abort,
                            input bit glitch);
        int exp_we, lim, we_cnt, we_t, bad_per, c, exp_cnt;
        logic [2:0] code;
        logic busy_we, p, q;
        exp_we = st[n-1] + 1 + GAP_BITS * NP;
        lim = abort ? (st[n-1] + wd[n-1] + 2) : (exp_we + 8);
        we_cnt = 0;
        we_t = -1;
        bad_per = 0;
        busy_we = 1'b0;
        for (int t = 0; t <= lim && !dead; t++) begin
            wait_tick(c);
            if (t > 0 && c != cur_div) bad_per++;
            if (w.word_end === 1'b1) begin
                we_cnt++;
                if (we_t < 0) begin
                    we_t = t;
                    busy_we = w.busy;
                end
            end
            p = 1'b0;
            q = 1'b0;
            for (int i = 0; i < n; i++)
                if (t >= st[i] && t < st[i] + wd[i]) begin
                    if (ln[i] != 1) p = 1'b1;
                    if (ln[i] != 0) q = 1'b1;
                end
            w.rxp = p;
            w.rxn = q;
            if (glitch && t == st[5]) w.rate_sel = 2'b10;
            if (glitch && t == st[20]) w.rate_sel = 2'b00;
        end
        chk({tag, "_ce_period"}, bad_per, 0);
        if (abort) return;
        exp_cnt = (n > 255) ? 255 : n;
        code = '0;
        code[0] = (exp_cnt != WORD_BITS);
        for (int i = 0; i < n; i++) if (ln[i] == 2) code[1] = 1'b1;
`ifdef RX_WORD_TIMER_SPACING_CHECK_EN
        for (int i = 1; i < n; i++)
            if (st[i] - st[i-1] < NP - TOL || st[i] - st[i-1] > NP + TOL)
                code[2] = 1'b1;
`endif
        chk({tag, "_we_count"}, we_cnt, 1);
        chk({tag, "_we_tick"}, we_t, exp_we);
        chk({tag, "_busy_at_we"}, busy_we, 1);
        @(negedge clk);
        chk({tag, "_n_pulses"}, w.n_pulses, exp_cnt);
        chk({tag, "_err_code"}, w.err_code, code);
        chk({tag, "_err"}, w.err, |code);
        chk({tag, "_busy_idle"}, w.busy, 0);
    endtask

    task automatic period(input logic [1:0] sel, input int exp);
        int c;
        w.rate_sel = sel;
        repeat (3) wait_tick(c);
        wait_tick(c);
        chk($sformatf("period_sel%0d", sel), c, exp);
    endtask

    initial begin
        int c;
        w.rate_sel = 2'b00;
        w.rxp = 1'b0;
        w.rxn = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_ce", w.ce, 0);
        chk("rst_busy", w.busy, 0);
        chk("rst_n_pulses", w.n_pulses, 0);
        chk("rst_err_code", w.err_code, 0);
        rst_n = 1'b1;
        wait_tick(c);
        chk("first_ce", c, 5);

        period(2'b01, 10);
        period(2'b10, 40);
        period(2'b11, 40);
        period(2'b00, 5);

        build(32, -1, -1, 0, 1'b0);
        run_word("w32", 1'b0, 1'b0);
        build(31, -1, -1, 0, 1'b0);
        run_word("w31", 1'b0, 1'b0);
        build(32, 4, -1, 0, 1'b0);
        run_word("both", 1'b0, 1'b0);

        period(2'b10, 40);
        cur_div = 40;
        build(32, -1, -1, 0, 1'b0);
        run_word("slow", 1'b0, 1'b0);
        period(2'b00, 5);
        cur_div = 5;

        build(32, -1, 9, 4, 1'b0);
        run_word("delay", 1'b0, 1'b0);
        build(24 + $urandom_range(16), -1, -1, 0, 1'b1);
        run_word("rnd", 1'b0, 1'b1);

        build(16, -1, -1, 0, 1'b1);
        run_word("abort", 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_ce", w.ce, 0);
        chk("mid_rst_we", w.word_end, 0);
        chk("mid_rst_busy", w.busy, 0);
        chk("mid_rst_n_pulses", w.n_pulses, 0);
        chk("mid_rst_err", w.err, 0);
        chk("mid_rst_err_code", w.err_code, 0);
        rst_n = 1'b1;
        wait_tick(c);
        chk("rel_first_ce", c, 5);
        build(32, -1, -1, 0, 1'b1);
        run_word("after_rst", 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
